// File: rtl/i2c_mon_pkg.sv
// Shared types and default sizing for the I2C pad-side bus monitor.
package i2c_mon_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      BUSY      = 2'd1,
      FREE_WAIT = 2'd2
   } bus_state_e;

   localparam int unsigned SYNC_STAGES_DEF  = 32'd2;
   localparam int unsigned FILT_LEN_DEF     = 32'd4;
   localparam int unsigned BUS_FREE_CYC_DEF = 32'd64;
   // CNT_W must be wide enough to hold max(FILT_LEN, BUS_FREE_CYC).
   localparam int unsigned CNT_W_DEF        = 32'd8;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizer and stability filter for one I2C line. o_line is the filtered
// register; o_line_nxt is the value it will hold after the next clock edge.
module i2c_line_filter
   import i2c_mon_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int unsigned FILT_LEN    = FILT_LEN_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
)(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_pad,
   output logic o_line,
   output logic o_line_nxt
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_line;
   logic                   w_synced;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic                   w_line_nxt;

   assign w_synced = r_sync[SYNC_STAGES-1];

   // Idle-high synchronizer chain.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= {SYNC_STAGES{1'b1}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
      end
   end

   always_comb begin
      w_line_nxt = r_line;
      w_cnt_nxt  = {CNT_W{1'b0}};
      if (w_synced != r_line) begin
         if (r_cnt == CNT_W'(FILT_LEN - 32'd1)) begin
            w_line_nxt = w_synced;
            w_cnt_nxt  = {CNT_W{1'b0}};
         end else begin
            w_cnt_nxt  = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end else begin
         w_cnt_nxt = {CNT_W{1'b0}};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt  <= {CNT_W{1'b0}};
         r_line <= 1'b1;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_line <= w_line_nxt;
      end
   end

   assign o_line     = r_line;
   assign o_line_nxt = w_line_nxt;

endmodule

// File: rtl/i2c_bus_monitor.sv
// I2C pad-side front end: filtered lines, SCL edges, START/STOP events,
// bus busy tracking, clock-stretch and arbitration-loss flags.
module i2c_bus_monitor
   import i2c_mon_pkg::*;
#(
   parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF,
   parameter int unsigned FILT_LEN     = FILT_LEN_DEF,
   parameter int unsigned BUS_FREE_CYC = BUS_FREE_CYC_DEF,
   parameter int unsigned CNT_W        = CNT_W_DEF
)(
   input  logic wb_clk_i,
   input  logic wb_rst_ni,
   input  logic scl_pad_i,
   input  logic sda_pad_i,
   input  logic master_active_i,
   input  logic scl_rel_i,
   input  logic sda_rel_i,
   input  logic arb_clr_i,
   output logic scl_o,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic rstart_o,
   output logic stop_o,
   output logic bus_busy_o,
   output logic scl_stretch_o,
   output logic arb_lost_o
);

   bus_state_e       r_state;
   bus_state_e       w_state_nxt;
   logic [CNT_W-1:0] r_free_cnt;
   logic [CNT_W-1:0] w_free_nxt;
   logic [CNT_W-1:0] w_free_inc;
   logic             w_scl, w_scl_nxt, w_sda, w_sda_nxt;
   logic             w_rise_ev, w_fall_ev, w_start_ev, w_stop_ev;
   logic             w_rstart_ev, w_busy_nxt, w_arb_set;
   logic             r_scl_rise, r_scl_fall, r_start, r_rstart, r_stop;
   logic             r_busy, r_stretch, r_arb_lost;

   i2c_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .CNT_W       (CNT_W)
   ) u_scl_filt (
      .i_clk      (wb_clk_i),
      .i_rst_n    (wb_rst_ni),
      .i_pad      (scl_pad_i),
      .o_line     (w_scl),
      .o_line_nxt (w_scl_nxt)
   );

   i2c_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .CNT_W       (CNT_W)
   ) u_sda_filt (
      .i_clk      (wb_clk_i),
      .i_rst_n    (wb_rst_ni),
      .i_pad      (sda_pad_i),
      .o_line     (w_sda),
      .o_line_nxt (w_sda_nxt)
   );

   // Events are decoded one edge early so the registered pulses line up with
   // the filtered line change (current register acts as the delayed copy).
   assign w_rise_ev  =  w_scl_nxt & ~w_scl;
   assign w_fall_ev  = ~w_scl_nxt &  w_scl;
   assign w_start_ev = ~w_sda_nxt &  w_sda & w_scl_nxt & w_scl;
   assign w_stop_ev  =  w_sda_nxt & ~w_sda & w_scl_nxt & w_scl;
   assign w_free_inc = r_free_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state    <= IDLE;
         r_free_cnt <= {CNT_W{1'b0}};
      end else begin
         r_state    <= w_state_nxt;
         r_free_cnt <= w_free_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_free_nxt  = r_free_cnt;
      case (r_state)
         IDLE: begin
            if (r_start || r_scl_fall) begin
               w_state_nxt = BUSY;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         BUSY: begin
            if (r_stop) begin
               w_state_nxt = FREE_WAIT;
               w_free_nxt  = {CNT_W{1'b0}};
            end else begin
               w_state_nxt = BUSY;
            end
         end
         FREE_WAIT: begin
            if (r_start || r_scl_fall) begin
               w_state_nxt = BUSY;
            end else if (w_scl && w_sda) begin
               w_free_nxt = w_free_inc;
               if (w_free_inc >= CNT_W'(BUS_FREE_CYC - 32'd1)) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = FREE_WAIT;
               end
            end else begin
               w_state_nxt = FREE_WAIT;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_free_nxt  = {CNT_W{1'b0}};
         end
      endcase
   end

   always_comb begin
      w_busy_nxt  = (w_state_nxt != IDLE);
      w_rstart_ev = w_start_ev & (w_state_nxt == BUSY);
   end

   // A START/STOP only counts against the master if its SDA release disagrees with the bus.
   assign w_arb_set = (r_scl_rise & master_active_i & sda_rel_i & ~w_sda)
                    | ((r_start | r_stop) & master_active_i & (r_state == BUSY) & (sda_rel_i ^ w_sda));

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_scl_rise <= 1'b0;
         r_scl_fall <= 1'b0;
         r_start    <= 1'b0;
         r_rstart   <= 1'b0;
         r_stop     <= 1'b0;
         r_busy     <= 1'b0;
         r_stretch  <= 1'b0;
         r_arb_lost <= 1'b0;
      end else begin
         r_scl_rise <= w_rise_ev;
         r_scl_fall <= w_fall_ev;
         r_start    <= w_start_ev;
         r_rstart   <= w_rstart_ev;
         r_stop     <= w_stop_ev;
         r_busy     <= w_busy_nxt;
         r_stretch  <= scl_rel_i & master_active_i & ~w_scl;
         if (w_arb_set) begin
            r_arb_lost <= 1'b1;
         end else if (arb_clr_i) begin
            r_arb_lost <= 1'b0;
         end else begin
            r_arb_lost <= r_arb_lost;
         end
      end
   end

   assign scl_o         = w_scl;
   assign sda_o         = w_sda;
   assign scl_rise_o    = r_scl_rise;
   assign scl_fall_o    = r_scl_fall;
   assign start_o       = r_start;
   assign rstart_o      = r_rstart;
   assign stop_o        = r_stop;
   assign bus_busy_o    = r_busy;
   assign scl_stretch_o = r_stretch;
   assign arb_lost_o    = r_arb_lost;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor: a table of pad vectors with expected
// settled outputs and pulse counts, plus timed sequences for the corner cases.
module tb_i2c_bus_monitor;

   localparam int EV_START = 0;
   localparam int EV_STOP  = 1;
   localparam int EV_FALL  = 2;
   localparam int EV_RISE  = 3;

   logic clk = 1'b0;
   logic rst_n, scl_pad, sda_pad, master, scl_rel, sda_rel, arb_clr;
   logic scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, rstart_o, stop_o;
   logic bus_busy_o, scl_stretch_o, arb_lost_o;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic scl;
      logic sda;
      int   hold;
      logic e_scl;
      logic e_sda;
      logic e_busy;
      int   e_start;
      int   e_stop;
      int   e_rise;
      int   e_fall;
   } vec_t;

   vec_t vecs[$];

   i2c_bus_monitor dut (
      .wb_clk_i        (clk),
      .wb_rst_ni       (rst_n),
      .scl_pad_i       (scl_pad),
      .sda_pad_i       (sda_pad),
      .master_active_i (master),
      .scl_rel_i       (scl_rel),
      .sda_rel_i       (sda_rel),
      .arb_clr_i       (arb_clr),
      .scl_o           (scl_o),
      .sda_o           (sda_o),
      .scl_rise_o      (scl_rise_o),
      .scl_fall_o      (scl_fall_o),
      .start_o         (start_o),
      .rstart_o        (rstart_o),
      .stop_o          (stop_o),
      .bus_busy_o      (bus_busy_o),
      .scl_stretch_o   (scl_stretch_o),
      .arb_lost_o      (arb_lost_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input int n);
      repeat (n) tick();
   endtask

   task automatic wait_evt(input int which, output int lat);
      lat = -1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if ((which == EV_START && start_o) || (which == EV_STOP && stop_o) ||
             (which == EV_FALL && scl_fall_o) || (which == EV_RISE && scl_rise_o)) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, "_scl"},     scl_o,         1);
      chk({pfx, "_sda"},     sda_o,         1);
      chk({pfx, "_rise"},    scl_rise_o,    0);
      chk({pfx, "_fall"},    scl_fall_o,    0);
      chk({pfx, "_start"},   start_o,       0);
      chk({pfx, "_rstart"},  rstart_o,      0);
      chk({pfx, "_stop"},    stop_o,        0);
      chk({pfx, "_busy"},    bus_busy_o,    0);
      chk({pfx, "_stretch"}, scl_stretch_o, 0);
      chk({pfx, "_arb"},     arb_lost_o,    0);
   endtask

   initial begin
      int lat, cnt, first;
      int c_start, c_rstart, c_stop, c_rise, c_fall, c_low;
      logic [8:0] bits;
      logic d;

      // scl, sda, hold, e_scl, e_sda, e_busy, e_start, e_stop, e_rise, e_fall
      vecs.push_back('{1'b1, 1'b1, 10, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0});
      vecs.push_back('{1'b1, 1'b0,  8, 1'b1, 1'b0, 1'b1, 1, 0, 0, 0});
      bits = {8'hA5, 1'b0};
      for (int b = 0; b < 9; b++) begin
         d = bits[8-b];
         vecs.push_back('{1'b0, d, 8, 1'b0, d, 1'b1, 0, 0, 0, 1});
         vecs.push_back('{1'b1, d, 8, 1'b1, d, 1'b1, 0, 0, 1, 0});
      end
      vecs.push_back('{1'b1, 1'b1,  8, 1'b1, 1'b1, 1'b1, 0, 1, 0, 0});
      vecs.push_back('{1'b1, 1'b1, 70, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0});

      rst_n = 1'b0; scl_pad = 1'b1; sda_pad = 1'b1;
      master = 1'b0; scl_rel = 1'b0; sda_rel = 1'b0; arb_clr = 1'b0;
      hold(3);
      chk_reset("por");
      rst_n = 1'b1;

      // Table: settled outputs and pulse counts per window
      for (int i = 0; i < vecs.size(); i++) begin
         scl_pad = vecs[i].scl;
         sda_pad = vecs[i].sda;
         c_start = 0; c_rstart = 0; c_stop = 0; c_rise = 0; c_fall = 0;
         for (int k = 0; k < vecs[i].hold; k++) begin
            tick();
            c_start += start_o; c_rstart += rstart_o; c_stop += stop_o;
            c_rise  += scl_rise_o; c_fall += scl_fall_o;
         end
         chk($sformatf("vec%0d_scl", i),    scl_o,      vecs[i].e_scl);
         chk($sformatf("vec%0d_sda", i),    sda_o,      vecs[i].e_sda);
         chk($sformatf("vec%0d_busy", i),   bus_busy_o, vecs[i].e_busy);
         chk($sformatf("vec%0d_start", i),  c_start,    vecs[i].e_start);
         chk($sformatf("vec%0d_rstart", i), c_rstart,   0);
         chk($sformatf("vec%0d_stop", i),   c_stop,     vecs[i].e_stop);
         chk($sformatf("vec%0d_rise", i),   c_rise,     vecs[i].e_rise);
         chk($sformatf("vec%0d_fall", i),   c_fall,     vecs[i].e_fall);
      end

      // 3-cycle glitch must be rejected
      sda_pad = 1'b0; hold(3); sda_pad = 1'b1;
      c_low = 0; c_start = 0; c_stop = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         c_low += !sda_o; c_start += start_o; c_stop += stop_o;
      end
      chk("glitch3_sda_low", c_low, 0);
      chk("glitch3_events", c_start + c_stop, 0);
      chk("glitch3_busy", bus_busy_o, 0);

      // 4-cycle pulse passes with 6-cycle latency (START then STOP)
      sda_pad = 1'b0;
      lat = -1; c_start = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 4) sda_pad = 1'b1;
         if (!sda_o && lat < 0) lat = k;
         c_start += start_o;
      end
      chk("pulse4_latency", lat, 6);
      chk("pulse4_start", c_start, 1);
      hold(80);
      chk("pulse4_idle", bus_busy_o, 0);

      // START from idle: busy the cycle after start_o
      sda_pad = 1'b0;
      wait_evt(EV_START, lat);
      chk("start_latency", lat, 6);
      chk("start_busy_before", bus_busy_o, 0);
      chk("start_rstart", rstart_o, 0);
      tick();
      chk("start_busy_after", bus_busy_o, 1);

      // Repeated START mid-transfer
      scl_pad = 1'b0; hold(10);
      sda_pad = 1'b1; hold(10);
      scl_pad = 1'b1; hold(10);
      sda_pad = 1'b0;
      wait_evt(EV_START, lat);
      chk("rstart_seen", lat, 6);
      chk("rstart_flag", rstart_o, 1);

      // STOP: bus reads free 64 cycles after stop_o
      sda_pad = 1'b1;
      wait_evt(EV_STOP, lat);
      chk("stop_seen", lat, 6);
      cnt = 0;
      while (bus_busy_o && cnt < 200) begin
         tick();
         cnt++;
      end
      chk("bus_free_delay", cnt, 64);

      // START in FREE_WAIT is not a repeated START
      sda_pad = 1'b0; wait_evt(EV_START, lat);
      sda_pad = 1'b1; wait_evt(EV_STOP, lat);
      chk("fw_stop_seen", lat, 6);
      hold(20);
      sda_pad = 1'b0;
      wait_evt(EV_START, lat);
      chk("fw_start_seen", lat, 6);
      chk("fw_rstart", rstart_o, 0);
      chk("fw_busy", bus_busy_o, 1);
      sda_pad = 1'b1; wait_evt(EV_STOP, lat);
      hold(80);
      chk("fw_idle", bus_busy_o, 0);

      // Arbitration on SCL rise with SDA held low externally
      sda_pad = 1'b0; hold(10);
      scl_pad = 1'b0; hold(10);
      master = 1'b1; sda_rel = 1'b1;
      chk("arb_before", arb_lost_o, 0);
      scl_pad = 1'b1;
      wait_evt(EV_RISE, lat);
      chk("arb_rise_seen", lat, 6);
      tick();
      chk("arb_set", arb_lost_o, 1);
      hold(5);
      chk("arb_sticky", arb_lost_o, 1);
      arb_clr = 1'b1; tick(); arb_clr = 1'b0;
      chk("arb_clear", arb_lost_o, 0);
      scl_pad = 1'b0; hold(10);
      scl_pad = 1'b1;
      wait_evt(EV_RISE, lat);
      arb_clr = 1'b1; tick(); arb_clr = 1'b0;
      chk("arb_set_wins", arb_lost_o, 1);
      arb_clr = 1'b1; tick(); arb_clr = 1'b0;
      chk("arb_clear2", arb_lost_o, 0);

      // STOP while driving consistently: no arbitration loss
      sda_pad = 1'b1;
      wait_evt(EV_STOP, lat);
      tick();
      chk("arb_stop_consistent", arb_lost_o, 0);
      master = 1'b0;
      hold(80);

      // STOP while core holds SDA low: arbitration loss
      sda_pad = 1'b0; hold(10);
      master = 1'b1; sda_rel = 1'b0;
      sda_pad = 1'b1;
      wait_evt(EV_STOP, lat);
      tick();
      chk("arb_stop_conflict", arb_lost_o, 1);
      master = 1'b0;
      arb_clr = 1'b1; tick(); arb_clr = 1'b0;
      chk("arb_clear3", arb_lost_o, 0);
      hold(80);

      // Clock stretch: pad held low 30 cycles
      master = 1'b1; scl_rel = 1'b1; sda_rel = 1'b0;
      scl_pad = 1'b0;
      cnt = 0; first = -1;
      for (int k = 1; k <= 50; k++) begin
         tick();
         if (k == 30) scl_pad = 1'b1;
         if (scl_stretch_o) begin
            cnt++;
            if (first < 0) first = k;
         end
      end
      chk("stretch_len", cnt, 30);
      chk("stretch_first", first, 7);
      master = 1'b0; scl_rel = 1'b0;

      // Both lines changing together: no START, no STOP
      scl_pad = 1'b0; sda_pad = 1'b0;
      c_start = 0; c_stop = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         c_start += start_o; c_stop += stop_o;
      end
      chk("simul_fall_start", c_start, 0);
      chk("simul_fall_lines", {scl_o, sda_o}, 0);
      scl_pad = 1'b1; sda_pad = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         c_start += start_o; c_stop += stop_o;
      end
      chk("simul_rise_stop", c_stop, 0);
      chk("simul_rise_lines", {scl_o, sda_o}, 3);

      // Reset during BUSY with SCL low
      scl_pad = 1'b0; hold(10);
      chk("prereset_scl", scl_o, 0);
      chk("prereset_busy", bus_busy_o, 1);
      rst_n = 1'b0;
      #1;
      chk_reset("midrst");
      tick(); tick();
      rst_n = 1'b1;
      wait_evt(EV_FALL, lat);
      chk("post_rst_fall", lat, 6);
      chk("post_rst_busy_at_fall", bus_busy_o, 0);
      tick();
      chk("post_rst_busy", bus_busy_o, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_bus_monitor.md
Name: i2c_bus_monitor

Overview:
Pad-side front end for the i2c core, placed between the SCL/SDA pad inputs (io_in[35:34]) and the core's bit engine. It synchronizes and deglitches both lines, produces SCL edge strobes and START/STOP/repeated-START events, and tracks bus busy/free state. It also flags clock stretching and arbitration loss. All outputs are registered in the wb_clk_i domain.

Parameters:
SYNC_STAGES, 2, synchronizer flops per line (min 2)
FILT_LEN, 4, consecutive stable cycles required before a filtered line changes (min 1)
BUS_FREE_CYC, 64, cycles both lines must stay high after STOP before the bus reads free
CNT_W, 8, width of the filter and bus-free counters; must hold max(FILT_LEN, BUS_FREE_CYC)

Ports:
wb_clk_i  in  1  system clock
wb_rst_ni  in  1  asynchronous active-low reset
scl_pad_i  in  1  raw SCL from pad
sda_pad_i  in  1  raw SDA from pad
master_active_i  in  1  core is currently bus master
scl_rel_i  in  1  core releases SCL (expects high)
sda_rel_i  in  1  core releases SDA (expects high)
arb_clr_i  in  1  clears arb_lost_o
scl_o  out  1  filtered SCL
sda_o  out  1  filtered SDA
scl_rise_o  out  1  one-cycle pulse on filtered SCL 0->1
scl_fall_o  out  1  one-cycle pulse on filtered SCL 1->0
start_o  out  1  one-cycle START pulse
rstart_o  out  1  one-cycle repeated-START pulse (START while busy)
stop_o  out  1  one-cycle STOP pulse
bus_busy_o  out  1  bus not free
scl_stretch_o  out  1  SCL released by core but held low externally
arb_lost_o  out  1  sticky arbitration-lost flag

Behaviour:
- Clock and reset: single clock wb_clk_i; wb_rst_ni is asynchronous, active-low.
- Reset values: synchronizer flops, scl_o and sda_o = 1; filter counters = 0; all pulses, scl_stretch_o and arb_lost_o = 0; state = IDLE, so bus_busy_o = 0.
- Filter, per line: a counter increments while the synced value differs from the filtered value and clears to 0 whenever they match. When the counter reaches FILT_LEN-1 and the mismatch persists, the filtered value flips and the counter clears. A pulse shorter than FILT_LEN cycles never reaches the output.
- Latency: pad change to filtered change = SYNC_STAGES + FILT_LEN cycles.
- Delayed copies scl_d and sda_d of the filtered lines are kept.
  - scl_rise_o = scl_o & ~scl_d; scl_fall_o = ~scl_o & scl_d.
- START: sda_o=0, sda_d=1, scl_o=1, scl_d=1. STOP: sda_o=1, sda_d=0, scl_o=1, scl_d=1.
- If SCL and SDA change in the same cycle, no START or STOP is reported.
- rstart_o pulses together with start_o when the state is BUSY.
- Bus state machine:
  - IDLE -> BUSY on START, or on scl_fall_o (a transfer already in progress at reset).
  - BUSY -> FREE_WAIT on STOP; the free counter is loaded with 0.
  - FREE_WAIT: the counter increments while scl_o=1 and sda_o=1. When it reaches BUSY_FREE_CYC-1, go to IDLE.
  - FREE_WAIT -> BUSY on START (start_o pulses, rstart_o does not) or on scl_fall_o.
  - bus_busy_o = (state != IDLE), registered.
- scl_stretch_o = scl_rel_i & master_active_i & ~scl_o, registered (1-cycle delay).
- Arbitration: arb_lost_o sets on a scl_rise_o cycle when master_active_i=1, sda_rel_i=1 and sda_o=0.
  - It also sets on a STOP or START detected while master_active_i=1 and the state is BUSY, unless the core is releasing and driving consistently: only when sda_rel_i disagrees with sda_o.
  - The flag stays set until arb_clr_i; if arb_clr_i and a set condition occur in the same cycle, set wins.
- Reset mid-operation: everything returns immediately to reset values. A low SCL is then followed by the filter latency and scl_fall_o, which moves the state to BUSY.

Decomposition:
- Package i2c_mon_pkg: bus state enum {IDLE, BUSY, FREE_WAIT}, default constants for FILT_LEN and BUS_FREE_CYC, and the CNT_W rule.
- Sub-module i2c_line_filter (synchronizer + stability filter + delayed copy), instantiated once for SCL and once for SDA.
- Event detection, the state machine and the arbitration/stretch logic live in the top module.

Test Plan:
- Glitch rejection: a 3-cycle low pulse on sda_pad_i with FILT_LEN=4 -> sda_o stays 1, no events. A 4-cycle pulse -> sda_o falls 6 cycles after the pad edge.
- START/STOP: SDA falls while SCL is high, then SCL toggles 9 times, then SDA rises with SCL high -> start_o once, 9 scl_rise_o pulses, stop_o once. bus_busy_o rises the cycle after start_o and falls 64 cycles after stop_o.
- Repeated START: a START issued 20 cycles after STOP (in FREE_WAIT) -> start_o=1, rstart_o=0. A START issued mid-transfer -> start_o=1, rstart_o=1.
- Arbitration: master_active_i=1, sda_rel_i=1, external SDA held 0 across an SCL rise -> arb_lost_o=1 and stays 1 until arb_clr_i. Simultaneous clear and set -> stays 1.
- Stretch and simultaneity: scl_rel_i=1 with the pad held low for 30 cycles -> scl_stretch_o high for that span, offset by latency. SCL and SDA changing in the same cycle -> no start_o or stop_o.
- Reset mid-busy: assert wb_rst_ni low during BUSY with SCL low -> all outputs immediately return to reset values. After release, scl_fall_o is seen after 6 cycles and bus_busy_o=1 one cycle later.
